// File: rtl/fig_04b_rom_fetch_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fig_04b_rom_fetch_arbiter_pkg
// Shared definitions for the GSU ROM fetch arbiter. It holds the FSM state
// codes, the grant codes, the default ROM wait-state count, and a small
// helper that picks the alternate requester.
// ---------------------------------------------------------------------------
package fig_04b_rom_fetch_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_INSTR = 1'b0,
    GNT_DATA  = 1'b1
  } grant_t;

  localparam int DEFAULT_WAIT_CYCLES = 3;

  function automatic grant_t other_grant(input grant_t g);
    return (g == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
  endfunction

endpackage

// File: rtl/fig_04b_rom_fetch_arbiter_rom_wait_counter.sv
// ---------------------------------------------------------------------------
// rom_wait_counter
// Down-counter that times one ROM access. A load presets the count. While
// enabled, the count decrements until it reaches zero, then holds there.
// Ports:
//   clk          in  clock
//   rst          in  synchronous active-high reset
//   i_load       in  preset the count to i_load_value
//   i_load_value in  preset value
//   i_enable     in  decrement while non-zero
//   o_zero       out count is zero
// ---------------------------------------------------------------------------
module rom_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_value,
  input  logic             i_enable,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_value;
    end else if (i_enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fig_04b_rom_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// fig_04b_rom_fetch_arbiter
// Arbiter and sequencer for the GSU side of the game-pak ROM bus. Two
// requesters compete for the bus: the instruction-cache fill (fetch_req,
// pbr/pc) and the ROM-buffer data load (data_req, data_bank/data_addr).
// Each grant drives {bank,addr} with rom_oe high for WAIT_CYCLES cycles and
// samples rom_data_in on the last one. The byte is returned with a
// one-cycle strobe, romrdy or data_rdy, on the following cycle.
// Ties alternate with the previous grant, so neither requester starves.
// Nothing is granted while ron is low, and ron falling during an access
// aborts it.
//
// Optional feature: macro SEQ_FETCH_EN (page-mode instruction fetch). An
// instruction fetch at last+1 in the same bank, following a completed
// instruction fetch, uses one fewer ROM cycle.
//
// Ports: clk, rst (sync, active-high), ron, fetch_req/pbr/pc ->
// romrdy/instr_data, data_req/data_bank/data_addr -> data_rdy/data_out,
// rom_addr/rom_oe/rom_data_in (ROM bus), busy (FSM not idle).
// ---------------------------------------------------------------------------
module fig_04b_rom_fetch_arbiter
  import fig_04b_rom_fetch_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ron,
  input  logic        fetch_req,
  input  logic [7:0]  pbr,
  input  logic [15:0] pc,
  output logic        romrdy,
  output logic [7:0]  instr_data,
  input  logic        data_req,
  input  logic [7:0]  data_bank,
  input  logic [15:0] data_addr,
  output logic        data_rdy,
  output logic [7:0]  data_out,
  output logic [23:0] rom_addr,
  output logic        rom_oe,
  input  logic [7:0]  rom_data_in,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LOAD_FULL = CNT_W'(WAIT_CYCLES - 1);

  state_t           r_state;
  grant_t           r_grant;
  grant_t           r_last_grant;
  logic             r_romrdy;
  logic             r_data_rdy;
  logic [7:0]       r_instr_data;
  logic [7:0]       r_data_out;
  logic [23:0]      r_rom_addr;
  logic             r_rom_oe;

  logic             w_pick_valid;
  grant_t           w_pick;
  logic             w_load;
  logic [CNT_W-1:0] w_load_value;
  logic             w_zero;

  // Arbitration. A lone requester wins outright. A tie goes to whichever
  // requester was not granted last.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick       = GNT_INSTR;
    if (ron) begin
      if (fetch_req && data_req) begin
        w_pick_valid = 1'b1;
        w_pick       = other_grant(r_last_grant);
      end else if (fetch_req) begin
        w_pick_valid = 1'b1;
        w_pick       = GNT_INSTR;
      end else if (data_req) begin
        w_pick_valid = 1'b1;
        w_pick       = GNT_DATA;
      end
    end
  end

  assign w_load = (r_state == ST_IDLE) && w_pick_valid;

`ifdef SEQ_FETCH_EN
  // Page-mode tracker: the address of the last completed instruction
  // access. Any data grant or loss of the bus breaks the sequence.
  localparam logic [CNT_W-1:0] LOAD_SEQ =
    (WAIT_CYCLES >= 2) ? CNT_W'(WAIT_CYCLES - 2) : '0;

  logic        r_seq_valid;
  logic [23:0] r_seq_addr;
  logic [16:0] w_seq_pc_next;
  logic        w_seq_hit;

  // Computed 17 bits wide so that pc=FFFF never matches a wrapped 0000.
  assign w_seq_pc_next = {1'b0, r_seq_addr[15:0]} + 17'd1;
  assign w_seq_hit     = r_seq_valid && (w_pick == GNT_INSTR) &&
                         (pbr == r_seq_addr[23:16]) &&
                         ({1'b0, pc} == w_seq_pc_next);

  always_ff @(posedge clk) begin
    if (rst || !ron) begin
      r_seq_valid <= 1'b0;
      r_seq_addr  <= '0;
    end else if (w_load && (w_pick == GNT_DATA)) begin
      r_seq_valid <= 1'b0;
    end else if ((r_state == ST_ACCESS) && w_zero && (r_grant == GNT_INSTR)) begin
      r_seq_valid <= 1'b1;
      r_seq_addr  <= r_rom_addr;
    end
  end

  assign w_load_value = w_seq_hit ? LOAD_SEQ : LOAD_FULL;
`else
  assign w_load_value = LOAD_FULL;
`endif

  rom_wait_counter #(
    .CNT_W(CNT_W)
  ) u_wait (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .i_enable     (r_state == ST_ACCESS),
    .o_zero       (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= GNT_INSTR;
      r_last_grant <= GNT_INSTR;
      r_romrdy     <= 1'b0;
      r_data_rdy   <= 1'b0;
      r_instr_data <= '0;
      r_data_out   <= '0;
      r_rom_addr   <= '0;
      r_rom_oe     <= 1'b0;
    end else begin
      r_romrdy   <= 1'b0;
      r_data_rdy <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state    <= ST_ACCESS;
            r_grant    <= w_pick;
            r_rom_oe   <= 1'b1;
            r_rom_addr <= (w_pick == GNT_DATA) ? {data_bank, data_addr} : {pbr, pc};
          end
        end
        ST_ACCESS: begin
          if (!ron) begin
            // Abort: the bus is lost. The request stays pending, and
            // last_grant is left alone so the retry wins the same way.
            r_state  <= ST_IDLE;
            r_rom_oe <= 1'b0;
          end else if (w_zero) begin
            r_state      <= ST_DONE;
            r_rom_oe     <= 1'b0;
            r_last_grant <= r_grant;
            // A requester that gave up mid-access gets neither the byte nor
            // the strobe. Its output register keeps the previous value.
            if (r_grant == GNT_INSTR) begin
              if (fetch_req) begin
                r_instr_data <= rom_data_in;
                r_romrdy     <= 1'b1;
              end
            end else begin
              if (data_req) begin
                r_data_out <= rom_data_in;
                r_data_rdy <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign romrdy     = r_romrdy;
  assign data_rdy   = r_data_rdy;
  assign instr_data = r_instr_data;
  assign data_out   = r_data_out;
  assign rom_addr   = r_rom_addr;
  assign rom_oe     = r_rom_oe;
  assign busy       = (r_state != ST_IDLE);

endmodule
